// File: rtl/spell_spi_sram_pkg.sv
// Shared constants, FSM state type and lane helper for the SPI SRAM Wishbone bridge.
package spell_spi_sram_pkg;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam logic [7:0]  CMD_WRITE  = 8'h02;
  localparam int unsigned FRAME_BITS = 32;

  typedef enum logic [1:0] {StIdle, StShift, StAck, StGap} state_e;

  // Lowest set byte-lane; sel==0 never reaches the SPI side so its result is unused.
  function automatic logic [1:0] lowest_lane(input logic [3:0] sel);
    if (sel[0])      return 2'd0;
    else if (sel[1]) return 2'd1;
    else if (sel[2]) return 2'd2;
    else             return 2'd3;
  endfunction

endpackage

// File: rtl/spell_spi_shifter.sv
// Mode-0 SPI frame engine: shifts one FRAME_BITS frame MSB first and captures the last rx byte.
module spell_spi_shifter
  import spell_spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  done,
  output logic [7:0]            rx_byte
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BitLast = CntW'(FRAME_BITS - 1);

  logic                  active_q;
  logic                  sck_q;
  logic                  cs_n_q;
  logic [DivW-1:0]       div_q;
  logic [CntW-1:0]       bit_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [7:0]            rx_q;
  logic                  phase_end;

  assign phase_end = active_q && (div_q == DivLast);
  assign done      = phase_end && sck_q && (bit_q == BitLast) && !abort;
  assign sck       = sck_q;
  assign cs_n      = cs_n_q;
  assign mosi      = shreg_q[FRAME_BITS-1];
  assign rx_byte   = rx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rx_q     <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= frame;
    end else if (abort) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      div_q    <= '0;
      shreg_q  <= '0;
    end else if (active_q) begin
      if (phase_end) begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[6:0], miso};
        end else begin
          // Falling edge: the only place the outgoing bit may change.
          sck_q <= 1'b0;
          if (bit_q == BitLast) begin
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            shreg_q  <= '0;
          end else begin
            bit_q   <= bit_q + 1'b1;
            shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spell_spi_sram_wb.sv
// Wishbone classic slave serving each cycle as one byte transfer to a 23LC-style SPI SRAM.
module spell_spi_sram_wb
  import spell_spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [9:0]  wb_addr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  state_e                state_q;
  logic                  ack_q;
  logic                  busy_q;
  logic                  rd_q;
  logic [31:0]           dat_q;
  logic                  req;
  logic                  start;
  logic                  abort;
  logic                  done;
  logic [1:0]            lane;
  logic [9:0]            byte_addr;
  logic [7:0]            wr_byte;
  logic [7:0]            rx_byte;
  logic [FRAME_BITS-1:0] frame;
  logic                  unused_addr;

  assign unused_addr = ^wb_addr_i[1:0];
  assign req         = wb_cyc_i && wb_stb_i;
  assign lane        = lowest_lane(wb_sel_i);
  assign byte_addr   = {wb_addr_i[9:2], lane};
  assign wr_byte     = wb_dat_i[{lane, 3'b000} +: 8];
  assign frame       = {wb_we_i ? CMD_WRITE : CMD_READ, ADDR_BITS'(byte_addr),
                        wb_we_i ? wr_byte : 8'h00};
  assign start       = (state_q == StIdle) && req && (wb_sel_i != 4'b0000);
  assign abort       = (state_q == StShift) && !req;

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign busy     = busy_q;

  spell_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .frame  (frame),
    .miso   (spi_miso),
    .sck    (spi_sck),
    .cs_n   (spi_cs_n),
    .mosi   (spi_mosi),
    .done   (done),
    .rx_byte(rx_byte)
  );

  // The ack register lags the state by one edge, so ACK issues ack while GAP holds it visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            busy_q  <= 1'b1;
            rd_q    <= !wb_we_i && (wb_sel_i != 4'b0000);
            state_q <= (wb_sel_i != 4'b0000) ? StShift : StAck;
          end
        end
        StShift: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StGap;
          end else if (done) begin
            state_q <= StAck;
          end
        end
        StAck: begin
          ack_q <= 1'b1;
          if (rd_q) dat_q <= {4{rx_byte}};
          state_q <= StGap;
        end
        StGap: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spell_spi_sram_wb.sv
// Scoreboard bench: two DUTs (CLK_DIV 1 and 3), per-DUT SRAM model and ack monitor.
module tb_spell_spi_sram_wb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        cyc, stb, ack, busy, sck, csn, mosi;
  logic              we;
  logic [3:0]        sel;
  logic [9:0]        addr;
  logic [31:0]       wdat;
  logic [1:0][31:0]  dat_o;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    bit         spi;
    bit         rd;
    logic [31:0] frame;
    logic [7:0]  rbyte;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int unsigned Div = (g == 0) ? 1 : 3;
    logic        miso = 1'b0;
    int          acc = 0;
    int          rises = 0;
    int          last_rise = 0;
    logic [31:0] fr = '0;
    bit          csn_low = 1'b0;
    logic        pbusy = 1'b0;
    logic        psck = 1'b0;
    logic        pack = 1'b0;
    exp_t        e;

    spell_spi_sram_wb #(
      .CLK_DIV  (Div),
      .ADDR_BITS(16)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wb_cyc_i (cyc[g]),
      .wb_stb_i (stb[g]),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_addr_i(addr),
      .wb_dat_i (wdat),
      .wb_dat_o (dat_o[g]),
      .wb_ack_o (ack[g]),
      .spi_sck  (sck[g]),
      .spi_cs_n (csn[g]),
      .spi_mosi (mosi[g]),
      .spi_miso (miso),
      .busy     (busy[g])
    );

    always @(negedge clk) begin
      if (rst) begin
        pbusy = 1'b0;
        psck  = 1'b0;
        pack  = 1'b0;
        miso  = 1'b0;
      end else begin
        if (busy[g] && !pbusy) begin
          acc = cycle; rises = 0; fr = '0; csn_low = 1'b0;
        end
        if (!csn[g]) csn_low = 1'b1;
        if (sck[g] && !psck) begin
          if (rises > 0) chk($sformatf("sck_period_dut%0d", g), cycle - last_rise, 2 * Div);
          last_rise = cycle;
          fr = {fr[30:0], mosi[g]};
          rises++;
        end
        // SRAM model: data bits go out after the falling edge that ends address bit 23.
        if (!sck[g] && psck)
          miso = (rises >= 24 && rises <= 31 && exp_q.size() > 0) ?
                 exp_q[0].rbyte[31 - rises] : 1'b0;
        if (pack) chk("ack_width", 32'(ack[g]), 0);
        if (ack[g] && !pack) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack dut%0d: got ack, want none (t=%0t)", g, $time);
          end else begin
            e = exp_q.pop_front();
            chk("ack_dut", g, e.dut);
            chk("latency", cycle - acc, e.lat);
            chk("ack_cs_n", 32'(csn[g]), 1);
            if (e.spi) begin
              chk("mosi_frame", fr, e.frame);
              chk("sck_rises", rises, 32);
            end else begin
              chk("cs_n_never_low", 32'(csn_low), 0);
            end
            if (e.rd) chk("rdata", dat_o[g], {4{e.rbyte}});
          end
        end
        pbusy = busy[g];
        psck  = sck[g];
        pack  = ack[g];
      end
    end
  end

  task automatic push_exp(input int d, input bit rd, input bit spi, input logic [31:0] fr,
                          input logic [7:0] rb);
    exp_t e;
    e.dut = d; e.rd = rd; e.spi = spi; e.frame = fr; e.rbyte = rb;
    e.lat = spi ? 64 * ((d == 0) ? 1 : 3) + 1 : 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[d] && n < 400);
    if (!ack[d]) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d: got no ack, want ack within 400 cycles", d);
      exp_q.delete();
    end
  endtask

  task automatic req(input int d, input logic w, input logic [9:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input bit spi, input logic [31:0] fr,
                     input logic [7:0] rb);
    push_exp(d, !w && spi, spi, fr, rb);
    we = w; addr = a; sel = s; wdat = wd;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    wait_ack(d);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_idle(input int d, input logic [31:0] dat);
    chk("idle_cs_n", 32'(csn[d]), 1);
    chk("idle_sck", 32'(sck[d]), 0);
    chk("idle_ack", 32'(ack[d]), 0);
    chk("idle_busy", 32'(busy[d]), 0);
    chk("idle_dat", dat_o[d], dat);
  endtask

  initial begin
    int n;
    rst = 1'b1; cyc = '0; stb = '0; we = 1'b0; sel = '0; addr = '0; wdat = '0;
    repeat (3) @(negedge clk);
    chk_idle(0, 32'h0);
    chk_idle(1, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read at CLK_DIV=1: byte address 0x146.
    req(0, 1'b1, 10'h144, 4'b0100, 32'hA5A5A5A5, 1'b1, 32'h020146A5, 8'h00);
    req(0, 1'b0, 10'h144, 4'b0100, 32'h00000000, 1'b1, 32'h03014600, 8'h5A);
    repeat (5) @(negedge clk);
    chk("rdata_held", dat_o[0], 32'h5A5A5A5A);

    // Multi-lane select picks lane 1; writes leave read data alone.
    req(0, 1'b1, 10'h000, 4'b1010, 32'h11223344, 1'b1, 32'h02000133, 8'h00);
    chk("rdata_after_write", dat_o[0], 32'h5A5A5A5A);

    // No lanes selected: immediate ack, no SPI activity.
    req(0, 1'b1, 10'h200, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0, 8'h00);

    // Abort after 10 sck rises, then a clean frame.
    we = 1'b0; addr = 10'h3F0; sel = 4'b0001; cyc[0] = 1'b1; stb[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gen_dut[0].rises < 10 && n < 200);
    chk("abort_reached_rises", 32'(gen_dut[0].rises >= 10), 1);
    cyc[0] = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 32'(csn[0]), 1);
    chk("abort_sck", 32'(sck[0]), 0);
    chk("abort_ack", 32'(ack[0]), 0);
    stb[0] = 1'b0;
    repeat (10) @(negedge clk);
    req(0, 1'b1, 10'h144, 4'b0001, 32'h000000C3, 1'b1, 32'h020144C3, 8'h00);

    // Reset in the middle of a frame.
    we = 1'b1; addr = 10'h100; sel = 4'b0001; wdat = 32'h77; cyc[0] = 1'b1; stb[0] = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    chk_idle(0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // CLK_DIV=3, back-to-back reads with strobe held across both frames.
    push_exp(1, 1'b1, 1'b1, 32'h0303FF00, 8'h3C);
    push_exp(1, 1'b1, 1'b1, 32'h03001000, 8'hC3);
    we = 1'b0; addr = 10'h3FC; sel = 4'b1000; cyc[1] = 1'b1; stb[1] = 1'b1;
    wait_ack(1);
    addr = 10'h010; sel = 4'b0001;
    wait_ack(1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("rdata_b2b_held", dat_o[1], 32'hC3C3C3C3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
